spike_encoder: RTL and testbench
================================

SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter num_inputs, default 1: number of pixel channels and spike outputs.
REQ-002 SHALL have parameter pixel_width, default 8: intensity bits per channel, range 1..16.
REQ-003 SHALL have parameter window_length, default 256: encoding cycles per presentation, minimum 1.
REQ-004 SHALL have parameter lfsr_seed, default 16'hACE1: base seed for the per-channel LFSRs.
REQ-005 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  request to encode the current pixel_in.
REQ-008 SHALL have port pixel_in  input  num_inputs*pixel_width  packed intensities; channel i at bits [i*pixel_width +: pixel_width].
REQ-009 SHALL have port busy  output  1  encoding window in progress.
REQ-010 SHALL have port done  output  1  one-cycle end-of-window pulse.
REQ-011 SHALL have port spike_out  output  num_inputs  registered spike train; drives a neuron's spike_in directly.

Function
REQ-012 SHALL implement FSM states IDLE, ENCODE, DONE.
REQ-013 IDLE: start=1 sampled at edge k SHALL latch pixel_in, clear window counter, set busy=1 and move to ENCODE; start=0 keeps IDLE.
REQ-014 ENCODE: each edge SHALL update every spike_out[i] and increment the counter; after window_length ENCODE edges (edges k+1..k+window_length) SHALL move to DONE.
REQ-015 DONE: at edge k+window_length+1 SHALL set done=1, busy=0, spike_out=0; next edge SHALL return to IDLE with done=0.
REQ-016 spike_out SHALL be 0 outside edges k+1..k+window_length.
REQ-017 Each channel i SHALL own a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seeded lfsr_seed+i (mod 2^16), seed 0 replaced by 16'h0001.
REQ-018 LFSRs SHALL advance once per ENCODE edge only; not reseeded on start, so consecutive windows differ.
REQ-019 rnd_i SHALL be the low pixel_width bits of LFSR i before its advance; spike_out[i] <= (rnd_i < pixel_i) unsigned.
REQ-020 pixel_i = 0 SHALL never spike; pixel_i all-ones SHALL spike on every ENCODE edge (override of REQ-019).
REQ-021 start while busy=1 or during DONE SHALL be ignored; pixel_in changes after latch SHALL have no effect.
REQ-022 start held high continuously SHALL begin the next window on the first IDLE cycle after done.
REQ-023 Counter width SHALL be $clog2(window_length+1); no wrap before the window ends.
REQ-024 busy SHALL be 1 from edge k through edge k+window_length inclusive.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, busy=0, done=0, spike_out=0, counter=0, latched pixels=0, LFSR i = its REQ-017 seed.
REQ-026 rst asserted mid-window SHALL abort without a done pulse; first start after release behaves as from power-up.

Verification
REQ-027 Reset mid-ENCODE (window_length=16, cycle 5) -> all outputs 0 immediately; next window's spike pattern identical to a post-power-up window.
REQ-028 num_inputs=2, pixels 0 and 0, window_length=16, start at edge k -> zero spikes, busy high k..k+16, done=1 only after edge k+17.
REQ-029 pixel all-ones (8'hFF), window_length=16 -> exactly 16 spikes per channel, one per ENCODE edge.
REQ-030 pixel 8'h80, window_length=256 -> spike train bit-exact to a reference LFSR model; count within 104..152.
REQ-031 start pulsed again at ENCODE cycle 3 and pixel_in changed at cycle 4 -> no restart, output unchanged, single done pulse.
REQ-032 start held high across three windows -> three done pulses, each window separated by exactly one IDLE cycle, spike patterns differ between windows.

Source files
------------

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: each channel compares its latched pixel against a
// per-channel LFSR sample on every cycle of a fixed-length encoding window.
module spike_encoder #(
  parameter int          num_inputs    = 1,
  parameter int          pixel_width   = 8,
  parameter int          window_length = 256,
  parameter logic [15:0] lfsr_seed     = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [num_inputs*pixel_width-1:0] pixel_in,
  output logic                              busy,
  output logic                              done,
  output logic [num_inputs-1:0]             spike_out
);

  localparam int cnt_width = $clog2(window_length + 1);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } state_t;

  state_t                            state;
  state_t                            state_next;
  logic [cnt_width-1:0]              cnt;
  logic [num_inputs*pixel_width-1:0] pix_q;
  logic                              last_cycle;

  assign last_cycle = (cnt == cnt_width'(window_length - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ENCODE;
      ENCODE:  if (last_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered from the DONE state, so it lands one edge after the
  // last spike and drops again on the following IDLE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      pix_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            pix_q <= pixel_in;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ENCODE: begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < num_inputs; g++) begin : g_ch
    localparam logic [15:0] seed_raw = 16'(lfsr_seed + 16'(g));
    localparam logic [15:0] seed     = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;

    logic [15:0]            lfsr;
    logic [pixel_width-1:0] pix;
    logic [pixel_width-1:0] rnd;
    logic                   fire;
    logic                   spike_q;

    assign pix  = pix_q[g*pixel_width +: pixel_width];
    assign rnd  = lfsr[pixel_width-1:0];
    // Full-scale pixel must fire every cycle even though rnd can equal it.
    assign fire = (pix == '1) || (rnd < pix);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lfsr    <= seed;
        spike_q <= 1'b0;
      end else if (state == ENCODE) begin
        lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        spike_q <= fire;
      end else begin
        spike_q <= 1'b0;
      end
    end

    assign spike_out[g] = spike_q;
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: one 2-channel 16-cycle instance and one
// 1-channel 256-cycle instance, with an LFSR reference model for spike trains.
module tb_spike_encoder;

  logic        clk;
  logic        rst;
  logic        start_a;
  logic [15:0] pixel_a;
  logic        busy_a;
  logic        done_a;
  logic [1:0]  spike_a;
  logic        start_b;
  logic [7:0]  pixel_b;
  logic        busy_b;
  logic        done_b;
  logic [0:0]  spike_b;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m0, m1, mb;
  logic [15:0] pu0, pu1, w1p, w2p, w3p, pr0, pr1, tmp0, tmp1;
  int          cnt_b;

  spike_encoder #(
    .num_inputs   (2),
    .pixel_width  (8),
    .window_length(16),
    .lfsr_seed    (16'hACE1)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .pixel_in (pixel_a),
    .busy     (busy_a),
    .done     (done_a),
    .spike_out(spike_a)
  );

  spike_encoder #(
    .num_inputs   (1),
    .pixel_width  (8),
    .window_length(256),
    .lfsr_seed    (16'hACE1)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .pixel_in (pixel_b),
    .busy     (busy_b),
    .done     (done_b),
    .spike_out(spike_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one window on instance A from IDLE. inject re-pulses start and
  // changes pixel_in mid-window; hold leaves start high at the end.
  task automatic run_a(input logic [15:0] pix, input bit inject, input bit hold,
                       output logic [15:0] pat0, output logic [15:0] pat1);
    logic [7:0] p0, p1;
    logic [1:0] exp_s;
    p0 = pix[7:0];
    p1 = pix[15:8];
    pixel_a = pix;
    start_a = 1'b1;
    tick();
    chk("start_busy", busy_a, 1);
    chk("start_done", done_a, 0);
    chk("start_spike", spike_a, 0);
    if (!hold) start_a = 1'b0;
    pat0 = '0;
    pat1 = '0;
    for (int e = 1; e <= 16; e++) begin
      exp_s[0] = (p0 == 8'hFF) || (m0[7:0] < p0);
      exp_s[1] = (p1 == 8'hFF) || (m1[7:0] < p1);
      m0 = lstep(m0);
      m1 = lstep(m1);
      if (inject && e == 3) start_a = 1'b1;
      if (inject && e == 4) begin
        start_a = 1'b0;
        pixel_a = ~pix;
      end
      tick();
      chk("enc_spike", spike_a, exp_s);
      chk("enc_busy", busy_a, 1);
      chk("enc_done", done_a, 0);
      pat0[e-1] = spike_a[0];
      pat1[e-1] = spike_a[1];
    end
    tick();
    chk("end_done", done_a, 1);
    chk("end_busy", busy_a, 0);
    chk("end_spike", spike_a, 0);
    if (!hold) begin
      tick();
      chk("idle_done", done_a, 0);
      chk("idle_busy", busy_a, 0);
      tick();
      chk("idle2_done", done_a, 0);
      chk("idle2_busy", busy_a, 0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    start_a = 1'b0;
    pixel_a = '0;
    start_b = 1'b0;
    pixel_b = '0;
    m0 = 16'hACE1;
    m1 = 16'hACE2;
    mb = 16'hACE1;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_spike", spike_a, 0);
    chk("rst_busy_b", busy_b, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // power-up reference window
    run_a(16'h8080, 1'b0, 1'b0, pu0, pu1);

    // zero pixels never spike
    run_a(16'h0000, 1'b0, 1'b0, tmp0, tmp1);
    chk("zero_cnt0", $countones(tmp0), 0);
    chk("zero_cnt1", $countones(tmp1), 0);

    // full-scale pixels spike every cycle
    run_a(16'hFFFF, 1'b0, 1'b0, tmp0, tmp1);
    chk("ff_cnt0", $countones(tmp0), 16);
    chk("ff_cnt1", $countones(tmp1), 16);

    // mixed intensities
    run_a(16'h40C0, 1'b0, 1'b0, tmp0, tmp1);

    // restart attempt and pixel change mid-window are ignored
    run_a(16'h8033, 1'b1, 1'b0, tmp0, tmp1);

    // start held across three back-to-back windows
    run_a(16'h8080, 1'b0, 1'b1, w1p, tmp1);
    run_a(16'h8080, 1'b0, 1'b1, w2p, tmp1);
    run_a(16'h8080, 1'b0, 1'b0, w3p, tmp1);
    chk("hold_w12_differ", (w1p != w2p), 1);
    chk("hold_w23_differ", (w2p != w3p), 1);

    // asynchronous reset in the middle of a window
    pixel_a = 16'hFFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("pre_rst_spike", spike_a, 2'b11);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", busy_a, 0);
    chk("async_done", done_a, 0);
    chk("async_spike", spike_a, 0);
    @(negedge clk);
    rst = 1'b1;
    m0 = 16'hACE1;
    m1 = 16'hACE2;
    mb = 16'hACE1;
    tick();
    chk("post_rst_done", done_a, 0);
    chk("post_rst_busy", busy_a, 0);
    tick();
    chk("post_rst_done2", done_a, 0);
    run_a(16'h8080, 1'b0, 1'b0, pr0, pr1);
    chk("post_rst_pattern", {pr1, pr0}, {pu1, pu0});

    // 256-cycle window against the reference model
    pixel_b = 8'h80;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_start_busy", busy_b, 1);
    cnt_b = 0;
    for (int e = 1; e <= 256; e++) begin
      logic exp_b;
      exp_b = (mb[7:0] < 8'h80);
      mb = lstep(mb);
      tick();
      chk("b_spike", spike_b, exp_b);
      if (e == 256) chk("b_busy_last", busy_b, 1);
      cnt_b += int'(spike_b[0]);
    end
    tick();
    chk("b_done", done_b, 1);
    chk("b_busy_end", busy_b, 0);
    chk("b_count_range", (cnt_b >= 104 && cnt_b <= 152), 1);
    tick();
    chk("b_done_drop", done_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
